// File: rtl/codec_pkg.sv
// Shared block-codec definitions: block/word geometry and the word order used by
// the decoder, this unpacker and the encoder-side packer.
package codec_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef logic [BLOCK_W-1:0] block_t;

  // Stream slot i carries block lane WORD_ORDER[i] (y0, z0, y1, z1).
  localparam logic [1:0] WORD_ORDER [WORDS_PER_BLOCK] = '{2'd0, 2'd1, 2'd2, 2'd3};

  function automatic logic [WORD_W-1:0] block_word(input block_t blk, input logic [1:0] slot);
    logic [1:0] lane;
    lane = WORD_ORDER[slot];
    return blk[lane*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/block_fifo.sv
// Block FIFO with registered pointers; a push into a full FIFO is accepted
// only when the head is popped in the same cycle.
module block_fifo #(
  parameter int DEPTH   = 2,
  parameter int BLOCK_W = 128,
  parameter int CW      = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [BLOCK_W-1:0] din,
  input  logic               pop,
  output logic [BLOCK_W-1:0] head,
  output logic               push_ok,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  localparam int PW = $clog2(DEPTH);

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               pop_eff;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_eff = pop & ~empty;
  assign push_ok = push & (~full | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_eff);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_eff) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is unreset; occupancy lives entirely in the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/decoded_block_unpacker.sv
// Captures one decoded 128-bit block per rising edge of done, buffers it, and
// streams it out as four 32-bit words.
module decoded_block_unpacker
  import codec_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     done,
  input  logic [BLOCK_W-1:0]       data_in,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     hold,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Output handshake: a word transfers on every cycle where out_valid and
  // out_ready are both high; out_data/out_last hold while out_ready is low.

  logic         done_q, done_d;
  logic [1:0]   wsel_q, wsel_d;
  logic         overflow_q, overflow_d;
  logic         cap, pop_word, final_pop;
  logic         push_ok, full, empty;
  block_t       head;
  logic [CW-1:0] fifo_count;

  assign cap       = done & ~done_q;
  assign pop_word  = out_valid & out_ready;
  assign final_pop = pop_word & (wsel_q == 2'd3);

  block_fifo #(
    .DEPTH   (DEPTH),
    .BLOCK_W (BLOCK_W),
    .CW      (CW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (cap),
    .din     (data_in),
    .pop     (final_pop),
    .head    (head),
    .push_ok (push_ok),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_comb begin
    done_d     = done;
    wsel_d     = wsel_q;
    overflow_d = overflow_q | (cap & ~push_ok);
    if (pop_word) wsel_d = wsel_q + 2'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      wsel_q     <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      wsel_q     <= wsel_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = ~empty;
  assign out_data  = out_valid ? block_word(head, wsel_q) : '0;
  assign out_last  = out_valid & (wsel_q == 2'd3);
  assign hold      = full;
  assign overflow  = overflow_q;
  assign count     = fifo_count;

endmodule

// File: tb/tb_decoded_block_unpacker.sv
// Bench for decoded_block_unpacker: directed table, multi-cycle corner cases and
// random traffic checked against a word-queue reference model.
module tb_decoded_block_unpacker;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          done;
  logic [127:0]  data_in;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          hold;
  logic          overflow;
  logic [CW-1:0] count;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model: the pending word stream, in emission order.
  logic [31:0] exp_q[$];
  logic        m_prev;
  logic        m_ovf;

  always #5 clock = ~clock;

  decoded_block_unpacker #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .done      (done),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .hold      (hold),
    .overflow  (overflow),
    .count     (count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_prev = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_model();
    int sz, blocks;
    sz     = exp_q.size();
    blocks = (sz + 3) / 4;
    check("valid", 32'(out_valid), 32'(sz != 0));
    check("data", out_data, (sz != 0) ? exp_q[0] : 32'h0);
    check("last", 32'(out_last), 32'(sz % 4 == 1));
    check("count", 32'(count), 32'(blocks));
    check("hold", 32'(hold), 32'(blocks == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_step(input logic d, input logic [127:0] di, input logic r);
    int  sz, blocks;
    logic cap, pop, fin;
    sz     = exp_q.size();
    blocks = (sz + 3) / 4;
    cap    = d & ~m_prev;
    m_prev = d;
    pop    = (sz != 0) && r;
    fin    = pop && (sz % 4 == 1);
    if (pop) void'(exp_q.pop_front());
    if (cap) begin
      if (blocks < DEPTH || (blocks == DEPTH && fin)) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(di[32*i +: 32]);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Called at a negedge: drive inputs, advance model, check at the next negedge.
  task automatic cycle(input logic d, input logic [127:0] di, input logic r);
    done = d; data_in = di; out_ready = r;
    model_step(d, di, r);
    @(posedge clock);
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; done = 1'b0; out_ready = 1'b0; data_in = '0;
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_model();
  endtask

  typedef struct {
    logic        d;
    logic [127:0] di;
    logic        r;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [127:0] blk_a, blk_b, blk_c;
    int peak;

    blk_a = 128'h44444444_33333333_22222222_11111111;
    blk_b = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    blk_c = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;

    tbl[0] = '{1'b1, blk_a, 1'b1, 1'b1, 32'h11111111, 1'b0};
    tbl[1] = '{1'b0, blk_a, 1'b1, 1'b1, 32'h22222222, 1'b0};
    tbl[2] = '{1'b0, blk_a, 1'b1, 1'b1, 32'h33333333, 1'b0};
    tbl[3] = '{1'b0, blk_a, 1'b1, 1'b1, 32'h44444444, 1'b1};
    tbl[4] = '{1'b0, blk_a, 1'b1, 1'b0, 32'h00000000, 1'b0};
    tbl[5] = '{1'b0, blk_a, 1'b1, 1'b0, 32'h00000000, 1'b0};

    // Reset state, with clocks running under reset.
    reset = 1'b1; done = 1'b0; out_ready = 1'b0; data_in = '0;
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_hold", 32'(hold), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    check_model();

    // Single block, table-driven.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].d, tbl[i].di, tbl[i].r);
      check("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
      check("tbl_data", out_data, tbl[i].e_data);
      check("tbl_last", 32'(out_last), 32'(tbl[i].e_last));
    end

    // Long done: one capture only.
    peak = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(i < 10, blk_b, 1'b1);
      if (int'(count) > peak) peak = int'(count);
    end
    check("long_done_peak", 32'(peak), 32'd1);

    // Backpressure: fill, drop a third block, then drain.
    cycle(1'b1, blk_a, 1'b0);
    for (int i = 0; i < 65; i++) cycle(1'b0, blk_a, 1'b0);
    cycle(1'b1, blk_b, 1'b0);
    for (int i = 0; i < 65; i++) cycle(1'b0, blk_b, 1'b0);
    check("bp_count_full", 32'(count), 32'(DEPTH));
    check("bp_hold", 32'(hold), 32'h1);
    cycle(1'b1, blk_c, 1'b0);
    cycle(1'b0, blk_c, 1'b0);
    check("bp_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 10; i++) cycle(1'b0, blk_c, 1'b1);
    check("bp_drained", 32'(out_valid), 32'h0);

    // Simultaneous capture and final pop on a full buffer.
    do_reset();
    cycle(1'b1, blk_a, 1'b0);
    cycle(1'b0, blk_a, 1'b0);
    cycle(1'b1, blk_b, 1'b0);
    cycle(1'b0, blk_b, 1'b1);
    cycle(1'b0, blk_b, 1'b1);
    cycle(1'b0, blk_b, 1'b1);
    check("sim_last_ready", 32'(out_last), 32'h1);
    cycle(1'b1, blk_c, 1'b1);
    check("sim_count", 32'(count), 32'(DEPTH));
    check("sim_overflow", 32'(overflow), 32'h0);
    check("sim_head", out_data, 32'hBBBB0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, blk_c, 1'b1);

    // Stall pattern 1,0,0,1 then random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic d, r;
      logic [127:0] di;
      d  = ($urandom_range(0, 5) == 0);
      di = {$urandom, $urandom, $urandom, $urandom};
      if (i < 60) r = (i % 4 == 0) || (i % 4 == 3);
      else        r = $urandom_range(0, 2) != 0;
      cycle(d, di, r);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

    // Reset in the middle of a drain.
    do_reset();
    cycle(1'b1, blk_a, 1'b1);
    cycle(1'b0, blk_a, 1'b1);
    cycle(1'b0, blk_a, 1'b1);
    check("mid_word2", out_data, 32'h33333333);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_last", 32'(out_last), 32'h0);
    check("mid_rst_count", 32'(count), 32'h0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    check_model();
    cycle(1'b1, blk_c, 1'b1);
    check("post_rst_word0", out_data, 32'hCCCC0000);
    for (int i = 0; i < 6; i++) cycle(1'b0, blk_c, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
